pool2d_stream: RTL
==================

Name: pool2d_stream

Overview:
Streaming 2-D pooling engine, the parametrised successor of the fixed 2x2/stride-2 max-pool. It accepts one pixel per qualified cycle in raster order and emits one pooled pixel per completed POOL x POOL window (stride = POOL). It supports runtime-selectable max or average pooling, signed data, non-square frames, and frame-done signalling. It sits between conv/activation stages in the CNN datapath.

Parameters:
DATA_WIDTH, 32, pixel width, two's-complement signed
IMG_W, 100, input frame width in pixels (>= POOL)
IMG_H, 100, input frame height in pixels (>= POOL)
POOL, 2, window size and stride; power of two in {2,4,8}

Ports:
Clk  input  1  clock, rising-edge
Rst  input  1  asynchronous active-low reset
valid_in  input  1  data_in qualifier; pixel accepted on rising Clk when high
data_in  input  DATA_WIDTH  input pixel, raster order
mode  input  1  0 = max pool, 1 = average pool; sampled at frame start
valid_out  output  1  one-cycle pulse, data_out valid
data_out  output  DATA_WIDTH  pooled pixel
frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (Rst low, asynchronous): col/row counters = 0, horizontal partial = 0, line accumulator contents don't-care (overwritten on first use), mode_q = 0, valid_out = 0, data_out = 0, frame_done = 0.
- Counters: col 0..IMG_W-1, wraps to 0 and increments row; row 0..IMG_H-1, wraps to 0 (next frame). Counters advance only on accepted pixels; valid_in gaps of any length are allowed, and state holds during gaps.
- kx = col mod POOL, ky = row mod POOL, ox = col / POOL.
- Mode: mode_q <= mode on the accepted pixel at (row 0, col 0); that pixel and the rest of the frame use the new value. Mode changes mid-frame have no effect until the next frame.
- Accumulation width AW = DATA_WIDTH + 2*log2(POOL). op = signed max (max mode) or sign-extended add (average mode).
- Horizontal partial h: kx==0 -> h = x; else h = op(h, x).
- On kx==POOL-1, window row result r = op(h, x). Line accumulator (IMG_W/POOL entries x AW): ky==0 -> acc[ox] = r; else acc[ox] = op(acc[ox], r).
- On ky==POOL-1 and kx==POOL-1: result = op(acc[ox], r).
  - Max mode: data_out = result.
  - Average mode: data_out = result >>> log2(POOL*POOL), arithmetic shift (floor); no saturation needed.
- Latency: valid_out/data_out update on the rising edge that accepts the window's last pixel (registered output, visible the following cycle). data_out holds its value between pulses.
- Partial windows: pixels with col >= (IMG_W/POOL)*POOL or row >= (IMG_H/POOL)*POOL are accepted and counted but never contribute and never produce output.
- Output count per frame: (IMG_W/POOL)*(IMG_H/POOL).
- frame_done: pulses on the acceptance of pixel (IMG_H-1, IMG_W-1), coincident with the final valid_out when IMG_W and IMG_H are multiples of POOL.
- Back-to-back frames: no bubble required; the pixel after the frame end is (0,0) of the next frame.
- Reset mid-frame: all counters restart at (0,0) and the partially accumulated window is discarded, with no spurious valid_out.
- No backpressure: the downstream stage must accept every valid_out pulse.

Test Plan:
1. IMG_W=IMG_H=4, POOL=2, mode=0, data_in=0..15 continuous -> valid_out pulses after pixels 5, 7, 13, 15 with data_out 5, 7, 13, 15; frame_done pulses with the last pulse.
2. Same stimulus, mode=1 -> data_out 2, 4, 10, 12 (floor of 10/4, 18/4, 42/4, 50/4).
3. Signed: single 2x2 window -1, -2, -3, -4 -> max = -1; avg = floor(-10/4) = -3 (0x...FFFD).
4. IMG_W=5, IMG_H=4, POOL=2, data_in=0..19 with random valid_in gaps (1-5 cycles) -> exactly 4 outputs in max mode: 6, 8, 16, 18; column 4 ignored; no outputs during gaps.
5. mode toggled from 0 to 1 at pixel 3 of frame 1, held through frame 2 -> frame 1 gives all max results, frame 2 gives all average results, frames back-to-back with no bubble.
6. Rst asserted for 1 cycle after pixel 6 of a 4x4 frame, then 0..15 replayed -> no valid_out during or immediately after reset; outputs 5, 7, 13, 15 as in scenario 1.

Source files
------------

// File: rtl/pool2d_stream.sv
// Streaming POOL x POOL / stride-POOL pooling engine (max or floor-average) over a
// raster-order pixel stream, with one line of window partials held in a small buffer.
module pool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100,
  parameter int POOL       = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mode,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int LP = $clog2(POOL);
  localparam int AW = DATA_WIDTH + 2 * LP;
  localparam int OW = IMG_W / POOL;
  localparam int OH = IMG_H / POOL;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;

  function automatic logic signed [AW-1:0] pool_op(input logic avg,
                                                   input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  // Average divides by POOL*POOL with an arithmetic shift, i.e. floor; the sum
  // always fits AW, so no saturation is involved.
  function automatic logic [DATA_WIDTH-1:0] finalize(input logic avg,
                                                     input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = avg ? (v >>> (2 * LP)) : v;
    return s[DATA_WIDTH-1:0];
  endfunction

  logic [CW-1:0]          col_p0;
  logic [RW-1:0]          row_p0;
  logic                   mode_q;
  logic signed [AW-1:0]   h_p0;
  logic signed [AW-1:0]   acc [OW];
  logic                   vld_p1;
  logic                   done_p1;
  logic [DATA_WIDTH-1:0]  data_p1;

  logic                   first_px, last_col, last_row, in_win;
  logic                   kx_first, kx_last, ky_first, ky_last, mode_eff;
  logic [LP-1:0]          kx, ky;
  logic [XW-1:0]          ox;
  logic signed [AW-1:0]   x_ext, row_res, win_res;

  // Stage p0: window position decode and combine with the incoming pixel
  always_comb begin
    kx       = col_p0[LP-1:0];
    ky       = row_p0[LP-1:0];
    ox       = XW'(col_p0 >> LP);
    first_px = (col_p0 == '0) && (row_p0 == '0);
    last_col = (col_p0 == CW'(IMG_W - 1));
    last_row = (row_p0 == RW'(IMG_H - 1));
    in_win   = (int'(col_p0) < OW * POOL) && (int'(row_p0) < OH * POOL);
    kx_first = (kx == '0);
    kx_last  = (kx == LP'(POOL - 1));
    ky_first = (ky == '0);
    ky_last  = (ky == LP'(POOL - 1));
    mode_eff = first_px ? mode : mode_q;
    x_ext    = AW'($signed(data_in));
    row_res  = pool_op(mode_eff, h_p0, x_ext);
    win_res  = pool_op(mode_eff, acc[ox], row_res);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_p0  <= '0;
      row_p0  <= '0;
      mode_q  <= 1'b0;
      h_p0    <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col_p0 <= '0;
          row_p0 <= last_row ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
        if (first_px) mode_q <= mode;
        if (in_win) h_p0 <= kx_first ? x_ext : row_res;
        if (in_win && kx_last && ky_last) begin
          vld_p1  <= 1'b1;
          data_p1 <= finalize(mode_eff, win_res);
        end
        done_p1 <= last_col && last_row;
      end
    end
  end

  // Line buffer needs no reset: every entry is overwritten on the first window row
  always_ff @(posedge Clk) begin
    if (valid_in && in_win && kx_last)
      acc[ox] <= ky_first ? row_res : pool_op(mode_eff, acc[ox], row_res);
  end

  // Stage p1: registered outputs
  assign valid_out  = vld_p1;
  assign data_out   = data_p1;
  assign frame_done = done_p1;

endmodule
